camera_capture_ctrl: RTL
========================

// Module: camera_capture_ctrl
// PURPOSE
//   Parametrised successor to the camera pixel counter. Runs entirely in the pclk domain
//   (no derived half-rate clock) and assembles byte pairs from cam_data into 16-bit pixels.
//   Produces registered write address, data and strobe for the frame buffer.
//   Adds optional 2:1 decimation, per-frame geometry error detection, a frame-done
//   pulse and a frame counter. Sits between the camera pins and the frame-buffer write port.
// PARAMETERS
//   H_ACTIVE    640  pixels per line expected from camera
//   V_ACTIVE    480  lines per frame expected from camera
//   XW          10   width of wr_x
//   YW          10   width of wr_y
//   DECIM       0    0: full resolution; 1: keep even pixels of even lines, halve addresses
//   BYTE_ORDER  0    0: first byte of pair is wr_data[15:8]; 1: first byte is wr_data[7:0]
// PORTS
//   pclk        in   1       camera pixel clock, sole clock
//   reset       in   1       asynchronous, active-low reset
//   cam_vsync   in   1       camera VSYNC, high between frames
//   href        in   1       camera HREF, high during valid line bytes
//   cam_data    in   8       camera data byte, sampled on rising pclk
//   capture_en  in   1       allow capture of the next frame
//   wr_x        out  XW      pixel column of wr_data
//   wr_y        out  YW      pixel row of wr_data
//   wr_data     out  16      assembled pixel
//   wren        out  1       one-cycle write strobe for wr_x/wr_y/wr_data
//   frame_done  out  1       one-cycle pulse at end of a captured frame
//   line_err    out  1       sticky geometry error for the current/last frame
//   frame_cnt   out  8       count of completed captured frames, wraps 255->0
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE; x, y, byte phase, wr_x, wr_y, wr_data=0;
//   wren, frame_done, line_err=0; frame_cnt=0.
// - FSM:
//   - IDLE: wait cam_vsync==1 -> SYNC.
//   - SYNC: x=y=0 while waiting. On cam_vsync==0: capture_en==1 -> ACTIVE and clear
//     line_err; else -> IDLE.
//   - ACTIVE: capture. cam_vsync==1 -> pulse frame_done 1 cycle, frame_cnt+1, -> SYNC.
//   - capture_en is sampled only at SYNC exit; deasserting it mid-frame finishes the frame.
// - Byte phase:
//   - Toggles each pclk with href==1; forced to 0 whenever href==0.
//   - Phase 0 latches the first byte. Phase 1 completes the pixel.
// - Pixel write (ACTIVE, phase 1):
//   - Next cycle, wren=1 with wr_data={b0,b1} (BYTE_ORDER=0) or {b1,b0} (BYTE_ORDER=1),
//     wr_x=x, wr_y=y; then x increments. Latency: last byte sampled -> wren is 1 pclk.
//   - DECIM=1: wren only when x[0]==0 and y[0]==0; wr_x=x>>1, wr_y=y>>1.
// - Line end (href 1->0 in ACTIVE):
//   - If x!=0: y+1, x=0.
//   - x!=H_ACTIVE sets line_err. An odd trailing byte is dropped and sets line_err.
// - Overflow:
//   - Pixel with x>=H_ACTIVE or line with y>=V_ACTIVE: no wren, line_err=1, counters
//     saturate at H_ACTIVE/V_ACTIVE (no wrap into valid addresses).
// - Frame end:
//   - cam_vsync rise with y!=V_ACTIVE sets line_err in the same cycle as frame_done.
//   - line_err holds until next ACTIVE entry.
// - href high outside ACTIVE: ignored, no wren, no error.
// - Simultaneous vsync rise and pixel completion: the pixel is written, then frame_done
//   follows on the next cycle.
// - Reset mid-frame aborts with no frame_done; the next capture starts only after a
//   full vsync high->low.
// TESTING
// 1. Reset mid-line with href=1 -> all outputs 0 immediately (async), no wren until
//    next vsync fall.
// 2. 4x2 frame (H_ACTIVE=4, V_ACTIVE=2), bytes 0x01..0x10 -> 8 wren, first wr_data=0x0102 at
//    (0,0), last 0x0F10 at (3,1), frame_done once, frame_cnt=1, line_err=0.
// 3. Same with BYTE_ORDER=1 -> first wr_data=0x0201; DECIM=1 -> 2 writes at (0,0),(1,0).
// 4. Line of 5 pixels with H_ACTIVE=4 -> 4 wren, no 5th write, line_err=1 until next
//    frame start.
// 5. capture_en=0 at vsync fall -> no wren for that frame, frame_cnt unchanged; drop
//    capture_en mid-frame -> frame completes.
// 6. 256 frames captured -> frame_cnt wraps to 0, frame_done pulses exactly 256 times.

Source files
------------

// File: rtl/camera_capture_ctrl_if.sv
// Camera-side inputs and frame-buffer write port of camera_capture_ctrl.
// The controller takes the master modport; the camera/frame-buffer side takes slave.
interface camera_capture_ctrl_if #(
   parameter int unsigned XW = 10,
   parameter int unsigned YW = 10
);
   logic          cam_vsync;
   logic          href;
   logic [7:0]    cam_data;
   logic          capture_en;
   logic [XW-1:0] wr_x;
   logic [YW-1:0] wr_y;
   logic [15:0]   wr_data;
   logic          wren;
   logic          frame_done;
   logic          line_err;
   logic [7:0]    frame_cnt;

   modport master (
      input  cam_vsync, href, cam_data, capture_en,
      output wr_x, wr_y, wr_data, wren, frame_done, line_err, frame_cnt
   );

   modport slave (
      output cam_vsync, href, cam_data, capture_en,
      input  wr_x, wr_y, wr_data, wren, frame_done, line_err, frame_cnt
   );
endinterface

// File: rtl/camera_capture_ctrl.sv
// Camera capture controller: assembles byte pairs into 16-bit pixels in the pclk domain and
// issues registered frame-buffer writes, with optional 2:1 decimation and geometry checking.
module camera_capture_ctrl #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned XW         = 10,
   parameter int unsigned YW         = 10,
   parameter int unsigned DECIM      = 0,
   parameter int unsigned BYTE_ORDER = 0
) (
   input logic                   pclk,
   input logic                   reset,
   camera_capture_ctrl_if.master bus
);

   localparam logic [XW-1:0] HMax = XW'(H_ACTIVE);
   localparam logic [YW-1:0] VMax = YW'(V_ACTIVE);

   typedef enum logic [1:0] {StIdle, StSync, StActive} state_e;

   state_e        state_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          phase_q;
   logic          href_q;
   logic [7:0]    b0_q;
   logic [XW-1:0] wr_x_q;
   logic [YW-1:0] wr_y_q;
   logic [15:0]   wr_data_q;
   logic          wren_q;
   logic          frame_done_q;
   logic          line_err_q;
   logic [7:0]    frame_cnt_q;

   logic          pix_done;
   logic          line_end;
   logic          frame_end;
   logic          x_ok;
   logic          y_ok;
   logic          keep;
   logic          line_bad;
   logic [15:0]   pixel;
   logic [YW-1:0] y_line;
   logic [YW-1:0] y_final;

   always_comb begin
      pix_done  = bus.href & phase_q;
      line_end  = ~bus.href & href_q;
      // A pixel completing on the vsync edge is written first; the frame closes a cycle later.
      frame_end = bus.cam_vsync & ~pix_done;
      x_ok      = (x_q < HMax);
      y_ok      = (y_q < VMax);
      keep      = (DECIM == 0) || (!x_q[0] && !y_q[0]);
      line_bad  = (x_q != HMax) | phase_q;
      pixel     = (BYTE_ORDER != 0) ? {bus.cam_data, b0_q} : {b0_q, bus.cam_data};
      y_line    = y_q;
      if (x_q != '0 && y_ok) begin
         y_line = y_q + YW'(1);
      end
      y_final   = line_end ? y_line : y_q;
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         x_q          <= '0;
         y_q          <= '0;
         phase_q      <= 1'b0;
         href_q       <= 1'b0;
         b0_q         <= '0;
         wr_x_q       <= '0;
         wr_y_q       <= '0;
         wr_data_q    <= '0;
         wren_q       <= 1'b0;
         frame_done_q <= 1'b0;
         line_err_q   <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         wren_q       <= 1'b0;
         frame_done_q <= 1'b0;
         href_q       <= bus.href;
         phase_q      <= bus.href ? ~phase_q : 1'b0;
         if (bus.href && !phase_q) begin
            b0_q <= bus.cam_data;
         end

         unique case (state_q)
            StIdle: begin
               if (bus.cam_vsync) begin
                  state_q <= StSync;
               end
            end

            StSync: begin
               x_q <= '0;
               y_q <= '0;
               if (!bus.cam_vsync) begin
                  if (bus.capture_en) begin
                     state_q    <= StActive;
                     line_err_q <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end

            StActive: begin
               if (frame_end) begin
                  state_q      <= StSync;
                  frame_done_q <= 1'b1;
                  frame_cnt_q  <= frame_cnt_q + 8'd1;
                  if ((line_end && line_bad) || (y_final != VMax)) begin
                     line_err_q <= 1'b1;
                  end
               end else if (pix_done) begin
                  if (x_ok && y_ok) begin
                     if (keep) begin
                        wren_q    <= 1'b1;
                        wr_data_q <= pixel;
                        wr_x_q    <= (DECIM != 0) ? (x_q >> 1) : x_q;
                        wr_y_q    <= (DECIM != 0) ? (y_q >> 1) : y_q;
                     end
                  end else begin
                     line_err_q <= 1'b1;
                  end
                  // Saturate at H_ACTIVE so overlong lines never wrap into valid columns.
                  if (x_ok) begin
                     x_q <= x_q + XW'(1);
                  end
               end else if (line_end) begin
                  if (line_bad) begin
                     line_err_q <= 1'b1;
                  end
                  if (x_q != '0) begin
                     x_q <= '0;
                     y_q <= y_line;
                  end
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.wr_x       = wr_x_q;
   assign bus.wr_y       = wr_y_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.wren       = wren_q;
   assign bus.frame_done = frame_done_q;
   assign bus.line_err   = line_err_q;
   assign bus.frame_cnt  = frame_cnt_q;

endmodule
